serial_tx_4bits: RTL
====================

Name: serial_tx_4bits

Overview:
Parallel-to-serial transmitter for the 4-bit register datapath. Accepts a DATA_W-bit word over a valid/ready handshake and shifts it out on a single line as a UART-style frame: start bit, data bits LSB-first, stop bit. It sits between a parallel register stage and a one-wire link, and is the transmit end for a matching serial receiver.

Parameters:
DATA_W, 4, data bits per frame (1..8)
CLKS_PER_BIT, 4, clk cycles per serial bit (>=1)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
in_data  input  DATA_W  word to transmit
in_valid  input  1  in_data valid
in_ready  output  1  transmitter can accept a word
tx  output  1  serial line; idles high
busy  output  1  frame in progress
done  output  1  one-cycle pulse when the stop bit completes

Behaviour:
- Reset: asynchronous, active-high; clock clk. While reset is high: state=IDLE, tx=1, in_ready=1, busy=0, done=0; shift register, bit counter and baud counter are cleared.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1, in_ready=1, busy=0. A word is accepted on the rising edge where in_valid && in_ready. On that edge: latch in_data into the shift register, clear the baud counter, go to START, tx=0, in_ready=0, busy=1.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0. A bit period ends on the edge where the counter equals CLKS_PER_BIT-1. Each bit is held for exactly CLKS_PER_BIT cycles.
- START: tx=0 for one bit period, then go to DATA with tx=shift[0] and bit index 0.
- DATA: at the end of each bit period, shift right and increment the bit index. After bit DATA_W-1, go to STOP with tx=1.
- STOP: tx=1 for one bit period. At its end: go to IDLE, set in_ready=1 and busy=0, and pulse done=1 for exactly one cycle.
- Frame length: (DATA_W+2)*CLKS_PER_BIT cycles, measured from the accept edge to the edge that returns to IDLE. With defaults this is 24 cycles.
- The next word can be accepted on the edge after the return to IDLE, so back-to-back frames are separated by at least 1 idle cycle at tx=1.
- in_valid while in_ready=0 is ignored; in_data changes during a frame have no effect.
- CLKS_PER_BIT=1: every state lasts one cycle and the counter is held at 0.
- Reset mid-frame: tx returns to 1 immediately, the frame is abandoned and done does not pulse.
- Counter width: $clog2(CLKS_PER_BIT), minimum 1. Bit index width: $clog2(DATA_W), minimum 1.

Decomposition:
- Shared package serial_pkg: state enum (IDLE, START, DATA, STOP), line level constants LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1.
- One sub-module, baud_tick_gen: parameter CLKS_PER_BIT; inputs clk, reset, clear; output tick, high on the last cycle of each bit period. The FSM advances on tick.

Test Plan:
- Reset with tx monitored: assert reset mid-idle and mid-frame -> tx=1, in_ready=1, busy=0, done=0 immediately, with no clock edge needed.
- Defaults, send in_data=4'b1010 -> tx holds 0,0,1,0,1,1 for 4 cycles each; done pulses once 24 cycles after the accept edge; in_ready=1 on that same edge.
- in_valid held high with new data during a frame (4'b1010 then 4'b0111) -> the second word is accepted only after IDLE is re-entered; frame 2 carries bits 1,1,1,0 after its start bit; tx stays 1 for at least 1 cycle between frames.
- CLKS_PER_BIT=1, in_data=4'b0001 -> tx sequence 0,1,0,0,0,1 in consecutive cycles; done 6 cycles after accept.
- Reset pulse during DATA bit 2 of in_data=4'b1111 -> no done pulse; after release the block accepts 4'b0101 and transmits a clean, correct frame.
- in_valid=0 for 50 cycles -> tx stays 1, busy stays 0, done never pulses.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial link.
// Used by the transmitter and its baud tick generator.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_tx_4bits_baud_tick_gen.sv
// Bit-period counter for the serial transmitter.
// tick is high on the last cycle of each bit period.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == LAST);

  // Next count: cleared, wrapped at the last cycle, else advanced.
  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx_4bits.sv
// UART-style parallel-to-serial transmitter.
// Frame: start bit, data LSB-first, stop bit; outputs registered.
module serial_tx_4bits
  import serial_pkg::*;
#(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W =
    (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(DATA_W - 1);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              clear;
  logic              tick;
  logic [DATA_W-1:0] shift_sh;

  assign shift_sh = shift_q >> 1;
  assign clear    = (state_q == IDLE);

  assign tx       = tx_q;
  assign in_ready = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .reset(reset),
    .clear(clear),
    .tick (tick)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d    = LINE_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (in_valid && ready_q) begin
          shift_d = in_data;
          state_d = START;
          tx_d    = START_BIT;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          idx_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
            tx_d    = STOP_BIT;
          end else begin
            shift_d = shift_sh;
            idx_d   = idx_q + IDX_W'(1);
            tx_d    = shift_sh[0];
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = LINE_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= LINE_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule
